// File: rtl/onehot_pkg.sv
// Shared constants, entry payload and decode helper for the one-hot codec family.
package onehot_pkg;

    localparam int unsigned CODE_W     = 4;
    localparam int unsigned ONEHOT_W   = 16;
    localparam int unsigned CODE_MIN   = 1;
    localparam int unsigned CODE_MAX   = 10;
    localparam int unsigned BIT_OFFSET = 5;

    typedef struct packed {
        logic [ONEHOT_W-1:0] onehot;
        logic                err;
    } onehot_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic int unsigned occ_to_cnt(input occ_e occ);
        return 32'(occ);
    endfunction

    // Code 0 means "no bit set"; codes above CODE_MAX are flagged as errors.
    function automatic onehot_entry_t decode(input logic [CODE_W-1:0] code);
        onehot_entry_t e;
        e.onehot = '0;
        e.err    = 1'b0;
        if (32'(code) >= CODE_MIN && 32'(code) <= CODE_MAX) begin
            e.onehot = ONEHOT_W'(1) << (32'(code) + BIT_OFFSET);
        end else if (32'(code) > CODE_MAX) begin
            e.err = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/onehot_skid_fifo.sv
// Two-entry shift FIFO; the head always sits in slot0 so read data comes straight from a flop.
module onehot_skid_fifo
    import onehot_pkg::*;
#(
    parameter type         T     = onehot_entry_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_valid,
    output logic wr_ready,
    input  T     wr_data,
    output logic rd_valid,
    input  logic rd_ready,
    output T     rd_data
);

    occ_e occ_q, occ_d;
    T     slot0_q, slot0_d;
    T     slot1_q, slot1_d;
    logic wr_ready_q, wr_ready_d;
    logic rd_valid_q, rd_valid_d;
    logic push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            slot0_q    <= '0;
            slot1_q    <= '0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Occupancy transitions, slot shifting and registered handshake flags.
    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        push    = wr_valid && wr_ready_q;
        pop     = rd_valid_q && rd_ready;

        unique case ({push, pop})
            2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
            2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
            default: occ_d = occ_q;
        endcase

        if (pop) begin
            slot0_d = slot1_q;
        end
        if (push) begin
            if (occ_q == OCC_EMPTY || (occ_q == OCC_ONE && pop)) begin
                slot0_d = wr_data;
            end else begin
                slot1_d = wr_data;
            end
        end

        wr_ready_d = occ_to_cnt(occ_d) < DEPTH;
        rd_valid_d = occ_d != OCC_EMPTY;
    end

    assign wr_ready = wr_ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = slot0_q;

endmodule

// File: rtl/onehot_decoder.sv
// 4-to-16 one-hot decoder with a 2-entry output buffer and saturating illegal-code counter.
module onehot_decoder
    import onehot_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] out_onehot,
    output logic                out_err,
    output logic [CNT_W-1:0]    err_cnt
);

    onehot_entry_t wr_entry;
    onehot_entry_t head;
    logic          fifo_wr_ready;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        wr_entry = decode(in_code);
    end

    onehot_skid_fifo #(
        .T     (onehot_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (in_valid),
        .wr_ready (fifo_wr_ready),
        .wr_data  (wr_entry),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    // Count accepted illegal codes, holding at all-ones instead of wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_valid && fifo_wr_ready && wr_entry.err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    assign in_ready   = fifo_wr_ready;
    assign out_onehot = head.onehot;
    assign out_err    = head.err;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Randomised and directed bench for onehot_decoder against a queue-based reference model.
module tb_onehot_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_onehot;
    logic        out_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_q[$];
    int m_cnt;
    bit m_en;
    int pops;

    always #5 clk = ~clk;

    onehot_decoder #(.DEPTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_onehot(input int c);
        logic [15:0] one;
        one = 16'd1;
        if (c >= 1 && c <= 10) return one << (c + 5);
        return 16'd0;
    endfunction

    // Inverse mapping, written independently: position of the set bit minus five.
    function automatic int encode(input logic [15:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) r = i - 5;
        end
        return r;
    endfunction

    // Called at a negedge: check outputs, drive inputs, predict the next edge.
    task automatic step(input bit v, input int code, input bit ordy);
        bit push, pop;
        check_eq("in_ready", 32'(in_ready), 32'(m_en && m_q.size() < 2));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (m_q.size() > 0) begin
            check_eq("out_onehot", 32'(out_onehot), 32'(exp_onehot(m_q[0])));
            check_eq("out_err", 32'(out_err), 32'(m_q[0] > 10));
        end
        in_valid  = v;
        in_code   = 4'(code);
        out_ready = ordy;
        push = v && m_en && m_q.size() < 2;
        pop  = ordy && m_q.size() > 0;
        if (pop) begin
            if (m_q[0] >= 1 && m_q[0] <= 10)
                check_eq("roundtrip", 32'(encode(out_onehot)), 32'(m_q[0]));
            void'(m_q.pop_front());
            pops++;
        end
        if (push) begin
            m_q.push_back(code);
            if (code > 10 && m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        m_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_out_onehot", 32'(out_onehot), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        m_q.delete();
        m_cnt = 0;
        m_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cycles;
        in_valid  = 1'b0;
        in_code   = 4'd0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        pops      = 0;
        @(negedge clk);
        do_reset();

        // Sweep every code with the consumer always ready.
        for (int c = 0; c < 16; c++) step(1'b1, c, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);

        // Back-pressure fill, then drain with input held valid.
        step(1'b1, 3, 1'b0);
        step(1'b1, 4, 1'b0);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("hold_head", 32'(out_onehot), 32'h0100);
        step(1'b1, 7, 1'b0);
        check_eq("hold_head2", 32'(out_onehot), 32'h0100);
        step(1'b1, 9, 1'b1);
        check_eq("order_second", 32'(out_onehot), 32'h0200);
        step(1'b1, 9, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);

        // Saturation of the illegal-code counter.
        for (int i = 0; i < 260; i++) step(1'b1, 15, 1'b1);
        step(1'b0, 0, 1'b1);
        check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Reset while full discards everything.
        step(1'b1, 5, 1'b0);
        step(1'b1, 6, 1'b0);
        check_eq("pre_rst_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        do_reset();
        step(1'b0, 0, 1'b0);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Random traffic until 10k output transfers or the cycle budget runs out.
        pops   = 0;
        cycles = 0;
        while (pops < 10000 && cycles < 40000) begin
            int c;
            c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 10));
            step($urandom_range(0, 9) < 7, c, $urandom_range(0, 9) < 6);
            cycles++;
        end
        check_eq("xfer_budget", 32'(pops >= 10000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
